// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Round-robin arbiter sharing one DATA_W-wide memory port between two
// cache-line requesters. One transaction at a time: IDLE -> BUSY -> DONE.
// All outputs are registered. Requesters hold rqN_valid until they see
// their one-cycle rqN_ready pulse.
// Optional feature: define MEM_ARB_TIMEOUT_EN to abort a BUSY transaction
// after TIMEOUT cycles without mem_ready (reported through rsp_err).
module mem_port_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 128,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  // requester 0
  input  logic              rq0_valid,
  input  logic              rq0_rw,
  input  logic [ADDR_W-1:0] rq0_addr,
  input  logic [DATA_W-1:0] rq0_wdata,
  output logic              rq0_ready,
  output logic [DATA_W-1:0] rq0_rdata,
  // requester 1
  input  logic              rq1_valid,
  input  logic              rq1_rw,
  input  logic [ADDR_W-1:0] rq1_addr,
  input  logic [DATA_W-1:0] rq1_wdata,
  output logic              rq1_ready,
  output logic [DATA_W-1:0] rq1_rdata,
  // shared status
  output logic              rsp_err,
  output logic [1:0]        grant,
  // memory side
  output logic              mem_valid,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  // round-robin pointer: requester that wins when both are valid
  logic rr, rr_nxt;

  logic any_req;
  logic win;
  logic owner;
  logic abort;
  logic complete;

  logic              mem_valid_nxt, mem_rw_nxt;
  logic [ADDR_W-1:0] mem_addr_nxt;
  logic [DATA_W-1:0] mem_wdata_nxt;
  logic [1:0]        grant_nxt;
  logic              rq0_ready_nxt, rq1_ready_nxt;
  logic [DATA_W-1:0] rq0_rdata_nxt, rq1_rdata_nxt;
  logic              rsp_err_nxt;

  // Winner selection in IDLE: a lone requester wins, a tie goes to rr.
  always_comb begin
    any_req = rq0_valid | rq1_valid;
    if (rq0_valid && rq1_valid) win = rr;
    else                        win = rq1_valid;
  end

  // The grant register doubles as the record of the current owner.
  assign owner = grant[1];

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] busy_cnt;

  // BUSY-cycle counter: zero on the first BUSY cycle, saturates at TIMEOUT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_cnt <= '0;
    end else if (state != BUSY) begin
      busy_cnt <= '0;
    end else if (busy_cnt != CNT_W'(TIMEOUT)) begin
      busy_cnt <= busy_cnt + 1'b1;
    end
  end

  // A mem_ready arriving on the limit cycle still completes normally.
  assign abort = (state == BUSY) && !mem_ready && (busy_cnt == CNT_W'(TIMEOUT));
`else
  // No counter: BUSY waits for mem_ready indefinitely, rsp_err never rises.
  assign abort = 1'b0 && (TIMEOUT != 0);
`endif

  assign complete = mem_ready | abort;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (any_req)  state_nxt = BUSY;
      BUSY:    if (complete) state_nxt = DONE;
      DONE:                  state_nxt = IDLE;
      default:               state_nxt = IDLE;
    endcase
  end

  // Next values for the registered outputs and the rr pointer.
  always_comb begin
    mem_valid_nxt = mem_valid;
    mem_rw_nxt    = mem_rw;
    mem_addr_nxt  = mem_addr;
    mem_wdata_nxt = mem_wdata;
    grant_nxt     = grant;
    rq0_ready_nxt = rq0_ready;
    rq1_ready_nxt = rq1_ready;
    rq0_rdata_nxt = rq0_rdata;
    rq1_rdata_nxt = rq1_rdata;
    rsp_err_nxt   = rsp_err;
    rr_nxt        = rr;
    unique case (state)
      IDLE: begin
        if (any_req) begin
          mem_valid_nxt = 1'b1;
          mem_rw_nxt    = win ? rq1_rw    : rq0_rw;
          mem_addr_nxt  = win ? rq1_addr  : rq0_addr;
          mem_wdata_nxt = win ? rq1_wdata : rq0_wdata;
          grant_nxt     = win ? 2'b10     : 2'b01;
        end
      end
      BUSY: begin
        if (complete) begin
          mem_valid_nxt = 1'b0;
          rsp_err_nxt   = abort;
          rr_nxt        = ~owner;
          if (owner) begin
            rq1_ready_nxt = 1'b1;
            if (!abort && !mem_rw) rq1_rdata_nxt = mem_rdata;
          end else begin
            rq0_ready_nxt = 1'b1;
            if (!abort && !mem_rw) rq0_rdata_nxt = mem_rdata;
          end
        end
      end
      DONE: begin
        rq0_ready_nxt = 1'b0;
        rq1_ready_nxt = 1'b0;
        rsp_err_nxt   = 1'b0;
        grant_nxt     = '0;
      end
      default: ;
    endcase
  end

  // Output and rr registers; reset discards any in-flight transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_valid <= 1'b0;
      mem_rw    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      grant     <= '0;
      rq0_ready <= 1'b0;
      rq1_ready <= 1'b0;
      rq0_rdata <= '0;
      rq1_rdata <= '0;
      rsp_err   <= 1'b0;
      rr        <= 1'b0;
    end else begin
      mem_valid <= mem_valid_nxt;
      mem_rw    <= mem_rw_nxt;
      mem_addr  <= mem_addr_nxt;
      mem_wdata <= mem_wdata_nxt;
      grant     <= grant_nxt;
      rq0_ready <= rq0_ready_nxt;
      rq1_ready <= rq1_ready_nxt;
      rq0_rdata <= rq0_rdata_nxt;
      rq1_rdata <= rq1_rdata_nxt;
      rsp_err   <= rsp_err_nxt;
      rr        <= rr_nxt;
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Round-robin arbiter sharing the single 128-bit backing-memory port between two cache-line requesters (e.g. instruction-side and data-side cache controllers). Each requester drives a held-valid request and receives a one-cycle completion pulse with registered read data. The arbiter owns the memory-side handshake, runs one transaction at a time, and sits between the cache controllers and the memory model/interface.

## Interface
- ADDR_W, 32, address width
- DATA_W, 128, line width (memory data and requester data)
- TIMEOUT, 255, BUSY cycles without mem_ready before abort (used only with MEM_ARB_TIMEOUT_EN)
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- rqN_valid  in  1  request N (N=0,1) pending; held until rqN_ready sampled high
- rqN_rw  in  1  1=write, 0=read; stable while rqN_valid
- rqN_addr  in  ADDR_W  line address; stable while rqN_valid
- rqN_wdata  in  DATA_W  write line; stable while rqN_valid
- rqN_ready  out  1  one-cycle completion pulse to requester N
- rqN_rdata  out  DATA_W  read line captured at completion of N's transaction
- rsp_err  out  1  qualifies rqN_ready: 1 = transaction aborted by timeout
- grant  out  2  one-hot current owner (bit N), 0 in IDLE
- mem_valid  out  1  memory request
- mem_rw  out  1  1=write, 0=read
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write line
- mem_rdata  in  DATA_W  memory read line, valid when mem_ready
- mem_ready  in  1  memory completion, single cycle

## Operation
- States: IDLE, BUSY, DONE. All outputs registered.
- IDLE: if no rqN_valid, stay. Else select winner: only one valid -> that one; both valid -> requester indexed by rr pointer. At edge: latch winner's addr/rw/wdata into mem_addr/mem_rw/mem_wdata, mem_valid<=1, grant<=onehot(winner), -> BUSY.
- BUSY: mem_* held stable. On mem_ready: mem_valid<=0, rq{winner}_ready<=1, rq{winner}_rdata<=mem_rdata if read (unchanged if write), rsp_err<=0, rr<=other requester, -> DONE.
- DONE: rqN_ready<=0, rsp_err<=0, grant<=0, -> IDLE.
- rr: reset 0 (requester 0 priority). Updated only on completion (normal or timeout).
- Requester drops or changes rqN_valid on the edge where rqN_ready is sampled high; a still-high valid in IDLE is a new request.
- rqN_rdata holds value until next read completion for that requester.
- Reset values: state IDLE, rr 0, all outputs 0 (mem_valid, mem_rw, mem_addr, mem_wdata, rq0/1_ready, rq0/1_rdata, rsp_err, grant).
- Reset mid-transaction: everything returns to reset values immediately (asynchronous); in-flight transaction discarded, no completion pulse.

## Timing
- Request sampled in IDLE at edge E0 -> mem_valid high after E0.
- mem_ready ignored outside BUSY (including cycle after E0 is first BUSY cycle; ready in it counts).
- mem_ready sampled at edge Ek -> rqN_ready high for exactly cycle after Ek.
- Minimum request-to-ready: 2 cycles; minimum back-to-back issue spacing: 3 cycles (BUSY, DONE, IDLE).
- Both requesters continuously valid -> grants strictly alternate.

## Configuration
- MEM_ARB_TIMEOUT_EN defined: BUSY counter (width clog2(TIMEOUT+1)), cleared on entering BUSY; when it reaches TIMEOUT with mem_ready low, perform completion as normal but rsp_err<=1, rqN_rdata unchanged, mem_valid<=0, -> DONE. mem_ready in the same cycle as count==TIMEOUT wins (normal completion).
- Not defined: no counter; BUSY waits indefinitely; rsp_err tied 0.

## Test plan
- rq0 read addr 0x0000_4010, memory returns 0x0123..CDEF after 3 cycles -> mem_rw=0, mem_addr=0x0000_4010, rq0_ready one pulse, rq0_rdata=0x0123..CDEF, grant=01 during BUSY.
- rq1 write addr 0x0000_8020, wdata 0xA5 repeated -> mem_rw=1, mem_wdata=0xA5..A5, rq1_ready pulse, rq1_rdata unchanged (0).
- Both valid from reset, each 4 back-to-back reads, memory ready 1 cycle -> grant sequence 01,10,01,10,01,10,01,10; no starvation.
- rst_n low while BUSY -> mem_valid, grant, ready drop immediately; after release IDLE re-arbitrates with rr=0.
- With MEM_ARB_TIMEOUT_EN, TIMEOUT=8, memory never ready -> after 8 BUSY cycles rq0_ready=1 with rsp_err=1, mem_valid=0; next both-valid request grants rq1.
- Without macro, memory ready after 300 cycles -> normal completion, rsp_err=0.
